vga_pattern_gen: RTL and testbench

VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

---
 rtl/vga_pkg.sv | 24 ++
 rtl/vga_timing.sv | 85 ++++++++
 rtl/vga_pattern_gen.sv | 155 +++++++++++++++
 tb/tb_vga_pattern_gen.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA constants: default 640x480@60 timing and the pattern mode encoding.
package vga_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  typedef enum logic [1:0] {
    SOLID    = 2'd0,
    BARS     = 2'd1,
    CHECKER  = 2'd2,
    GRADIENT = 2'd3
  } pattern_mode_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-rate divider, h/v raster counters and registered sync/display_on/position outputs.
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
  parameter int unsigned H_FP      = DEF_H_FP,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BP      = DEF_H_BP,
  parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
  parameter int unsigned V_FP      = DEF_V_FP,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BP      = DEF_V_BP,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0,
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int unsigned CW       = $clog2(max_u(H_TOTAL, V_TOTAL))
) (
  input  logic          clk,
  input  logic          rst,
  output logic          tick,
  output logic [CW-1:0] h_cnt,
  output logic [CW-1:0] v_cnt,
  output logic          active,
  output logic          h_sync,
  output logic          v_sync,
  output logic          display_on,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          pix_tick,
  output logic          frame_start
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_q;
  logic [CW-1:0]    h_q, v_q;
  logic             h_wrap, v_wrap, in_hsync, in_vsync;

  // With CLK_DIV=1 the divider sits at 0 and tick is permanently high.
  assign tick   = (div_q == DIV_W'(CLK_DIV - 1));
  assign h_cnt  = h_q;
  assign v_cnt  = v_q;
  assign h_wrap = (32'(h_q) == H_TOTAL - 1);
  assign v_wrap = (32'(v_q) == V_TOTAL - 1);
  assign active = (32'(h_q) < H_ACTIVE) && (32'(v_q) < V_ACTIVE);

  assign in_hsync = (32'(h_q) >= H_ACTIVE + H_FP) && (32'(h_q) < H_ACTIVE + H_FP + H_SYNC);
  assign in_vsync = (32'(v_q) >= V_ACTIVE + V_FP) && (32'(v_q) < V_ACTIVE + V_FP + V_SYNC);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q       <= '0;
      h_q         <= '0;
      v_q         <= '0;
      h_sync      <= ~HSYNC_POL;
      v_sync      <= ~VSYNC_POL;
      display_on  <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_tick    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pix_tick    <= tick;
      frame_start <= tick && (h_q == '0) && (v_q == '0);
      if (tick) begin
        div_q <= '0;
        h_q   <= h_wrap ? '0 : h_q + 1'b1;
        if (h_wrap) begin
          v_q <= v_wrap ? '0 : v_q + 1'b1;
        end
        // Registered view reflects the counters as they were before this increment.
        h_sync     <= in_hsync ? HSYNC_POL : ~HSYNC_POL;
        v_sync     <= in_vsync ? VSYNC_POL : ~VSYNC_POL;
        display_on <= active;
        pix_x      <= h_q;
        pix_y      <= v_q;
      end else begin
        div_q <= div_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern generator: solid, colour bars, checkerboard and gradient on a parameterised
// raster, with per-frame latching of the pattern selection.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
  parameter int unsigned H_FP      = DEF_H_FP,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BP      = DEF_H_BP,
  parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
  parameter int unsigned V_FP      = DEF_V_FP,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BP      = DEF_V_BP,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0,
  parameter int unsigned COLOR_W   = 4,
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int unsigned CW       = $clog2(max_u(H_TOTAL, V_TOTAL))
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             mode,
  input  logic [3*COLOR_W-1:0]   solid_rgb,
  output logic [COLOR_W-1:0]     red,
  output logic [COLOR_W-1:0]     green,
  output logic [COLOR_W-1:0]     blue,
  output logic                   h_sync,
  output logic                   v_sync,
  output logic                   display_on,
  output logic [CW-1:0]          pix_x,
  output logic [CW-1:0]          pix_y,
  output logic                   pix_tick,
  output logic                   frame_start
);

  localparam int unsigned XW = $clog2(H_ACTIVE);
  localparam int unsigned YW = $clog2(V_ACTIVE);
  localparam int unsigned XR = (XW > COLOR_W) ? XW - COLOR_W : 0;
  localparam int unsigned XL = (COLOR_W > XW) ? COLOR_W - XW : 0;
  localparam int unsigned YR = (YW > COLOR_W) ? YW - COLOR_W : 0;
  localparam int unsigned YL = (COLOR_W > YW) ? COLOR_W - YW : 0;
  // Headroom so bit 5 always exists and left shifts never overflow.
  localparam int unsigned EW = CW + COLOR_W + 6;
  localparam bit BARS_POW2 = (H_ACTIVE >= 8) && ((H_ACTIVE & (H_ACTIVE - 1)) == 0);

  logic                 tick, active;
  logic [CW-1:0]        h_cnt, v_cnt;
  logic [EW-1:0]        hx, vx;
  logic [2:0]           bar_idx;
  logic                 chk;
  logic [COLOR_W-1:0]   grad_r, grad_g;
  logic                 frame_first;
  pattern_mode_e        mode_q, mode_sel;
  logic [3*COLOR_W-1:0] solid_q, solid_sel;
  logic [COLOR_W-1:0]   pat_r, pat_g, pat_b;

  vga_timing #(
    .CLK_DIV  (CLK_DIV),
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .HSYNC_POL(HSYNC_POL),
    .VSYNC_POL(VSYNC_POL)
  ) u_timing (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .active     (active),
    .h_sync     (h_sync),
    .v_sync     (v_sync),
    .display_on (display_on),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_tick   (pix_tick),
    .frame_start(frame_start)
  );

  assign hx = EW'(h_cnt);
  assign vx = EW'(v_cnt);

  generate
    if (BARS_POW2) begin : g_bar_shift
      assign bar_idx = 3'(hx >> (XW - 3));
    end else begin : g_bar_cmp
      always_comb begin
        bar_idx = '0;
        for (int unsigned k = 1; k < 8; k++) begin
          if (32'(h_cnt) >= (k * H_ACTIVE + 7) / 8) begin
            bar_idx = 3'(k);
          end
        end
      end
    end
  endgenerate

  assign chk    = hx[5] ^ vx[5];
  assign grad_r = COLOR_W'((hx >> XR) << XL);
  assign grad_g = COLOR_W'((vx >> YR) << YL);

  // The first pixel of a frame already uses the freshly sampled selection.
  assign frame_first = tick && (h_cnt == '0) && (v_cnt == '0);
  assign mode_sel    = frame_first ? pattern_mode_e'(mode) : mode_q;
  assign solid_sel   = frame_first ? solid_rgb : solid_q;

  always_comb begin
    pat_r = '0;
    pat_g = '0;
    pat_b = '0;
    unique case (mode_sel)
      SOLID:    {pat_r, pat_g, pat_b} = solid_sel;
      BARS: begin
        pat_r = {COLOR_W{bar_idx[2]}};
        pat_g = {COLOR_W{bar_idx[1]}};
        pat_b = {COLOR_W{bar_idx[0]}};
      end
      CHECKER: begin
        pat_r = {COLOR_W{chk}};
        pat_g = {COLOR_W{chk}};
        pat_b = {COLOR_W{chk}};
      end
      GRADIENT: begin
        pat_r = grad_r;
        pat_g = grad_g;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= SOLID;
      solid_q <= '0;
      red     <= '0;
      green   <= '0;
      blue    <= '0;
    end else if (tick) begin
      if (frame_first) begin
        mode_q  <= pattern_mode_e'(mode);
        solid_q <= solid_rgb;
      end
      red   <= active ? pat_r : '0;
      green <= active ? pat_g : '0;
      blue  <= active ? pat_b : '0;
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench: a full-width raster at CLK_DIV=4 and a tiny raster at CLK_DIV=1.
module tb_vga_pattern_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Instance A: 640-wide lines, 4 active lines, CLK_DIV=4 -> 800*7*4 = 22400 clk per frame.
  logic       a_rst;
  logic [1:0] a_mode;
  logic [11:0] a_solid;
  logic [3:0] a_red, a_green, a_blue;
  logic       a_h_sync, a_v_sync, a_display_on, a_pix_tick, a_frame_start;
  logic [9:0] a_pix_x, a_pix_y;

  vga_pattern_gen #(
    .CLK_DIV (4),
    .V_ACTIVE(4),
    .V_FP    (1),
    .V_SYNC  (1),
    .V_BP    (1)
  ) u_dut_a (
    .clk        (clk),
    .rst        (a_rst),
    .mode       (a_mode),
    .solid_rgb  (a_solid),
    .red        (a_red),
    .green      (a_green),
    .blue       (a_blue),
    .h_sync     (a_h_sync),
    .v_sync     (a_v_sync),
    .display_on (a_display_on),
    .pix_x      (a_pix_x),
    .pix_y      (a_pix_y),
    .pix_tick   (a_pix_tick),
    .frame_start(a_frame_start)
  );

  // Instance B: 8/1/2/1 x 4/1/1/1, CLK_DIV=1, active-high hsync -> 12*7 = 84 clk per frame.
  logic       b_rst;
  logic [1:0] b_mode;
  logic [11:0] b_solid;
  logic [3:0] b_red, b_green, b_blue;
  logic       b_h_sync, b_v_sync, b_display_on, b_pix_tick, b_frame_start;
  logic [3:0] b_pix_x, b_pix_y;

  vga_pattern_gen #(
    .CLK_DIV  (1),
    .H_ACTIVE (8),
    .H_FP     (1),
    .H_SYNC   (2),
    .H_BP     (1),
    .V_ACTIVE (4),
    .V_FP     (1),
    .V_SYNC   (1),
    .V_BP     (1),
    .HSYNC_POL(1'b1)
  ) u_dut_b (
    .clk        (clk),
    .rst        (b_rst),
    .mode       (b_mode),
    .solid_rgb  (b_solid),
    .red        (b_red),
    .green      (b_green),
    .blue       (b_blue),
    .h_sync     (b_h_sync),
    .v_sync     (b_v_sync),
    .display_on (b_display_on),
    .pix_x      (b_pix_x),
    .pix_y      (b_pix_y),
    .pix_tick   (b_pix_tick),
    .frame_start(b_frame_start)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance until A's registered outputs show pixel (x,y) on a tick.
  task automatic seek_a(input int x, input int y);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 30000 && !found; i++) begin
      @(posedge clk);
      #1;
      if (a_pix_tick && a_pix_x == 10'(x) && a_pix_y == 10'(y)) found = 1'b1;
    end
    check($sformatf("seek_a(%0d,%0d)", x, y), 32'(found), 32'd1);
  endtask

  int fa0, fa1, fa2;
  int idx, bx, by;
  logic [3:0] bxv;
  logic [11:0] b_exp_rgb;
  logic b_disp;

  initial begin
    a_rst = 1'b1; a_mode = 2'd1; a_solid = 12'h000;
    b_rst = 1'b1; b_mode = 2'd0; b_solid = 12'h5A3;
    repeat (3) @(posedge clk);
    #1;
    check("a_rst_pix_x", a_pix_x, 0);
    check("a_rst_pix_y", a_pix_y, 0);
    check("a_rst_rgb", {a_red, a_green, a_blue}, 12'h000);
    check("a_rst_syncs", {a_h_sync, a_v_sync}, 2'b11);
    check("a_rst_flags", {a_display_on, a_pix_tick, a_frame_start}, 3'b000);
    check("b_rst_syncs", {b_h_sync, b_v_sync}, 2'b01);
    check("b_rst_flags", {b_display_on, b_pix_tick, b_frame_start}, 3'b000);
    a_rst = 1'b0;
    b_rst = 1'b0;

    for (int n = 1; n <= 98; n++) begin
      @(posedge clk);
      #1;
      if (n <= 8) check("a_tick_period", a_pix_tick, 32'(n % 4 == 0));
      if (n == 4) begin
        fa0 = cyc;
        check("a_first_fs", a_frame_start, 1);
        check("a_first_xy", {a_pix_x, a_pix_y}, 20'h0);
        check("a_first_disp", a_display_on, 1);
        check("a_first_rgb", {a_red, a_green, a_blue}, 12'h000);
      end
      if (n == 8) check("a_second_tick", {a_pix_x, a_frame_start}, {10'd1, 1'b0});
      idx = n - 1;
      bx  = idx % 12;
      by  = (idx / 12) % 7;
      bxv = 4'(bx);
      b_disp = (bx < 8) && (by < 4);
      if (!b_disp) b_exp_rgb = 12'h000;
      else if (idx < 84) b_exp_rgb = 12'h5A3;
      else b_exp_rgb = {{4{bxv[2]}}, {4{bxv[1]}}, {4{bxv[0]}}};
      check("b_pix_tick", b_pix_tick, 1);
      check("b_pix_x", b_pix_x, 32'(bx));
      check("b_pix_y", b_pix_y, 32'(by));
      check("b_frame_start", b_frame_start, 32'(idx % 84 == 0));
      check("b_h_sync", b_h_sync, 32'(bx == 9 || bx == 10));
      check("b_v_sync", b_v_sync, 32'(by != 5));
      check("b_display_on", b_display_on, 32'(b_disp));
      check("b_rgb", {b_red, b_green, b_blue}, 32'(b_exp_rgb));
      if (n == 9) b_mode = 2'd1;
    end

    // Frame 0 of A: colour bars.
    seek_a(79, 0);  check("a_bar_79", {a_red, a_green, a_blue}, 12'h000);
    seek_a(80, 0);  check("a_bar_80", {a_red, a_green, a_blue}, 12'h00F);
    @(posedge clk);
    #1;
    check("a_hold_tick", a_pix_tick, 0);
    check("a_hold_x", a_pix_x, 80);
    check("a_hold_rgb", {a_red, a_green, a_blue}, 12'h00F);
    seek_a(160, 0); check("a_bar_160", {a_red, a_green, a_blue}, 12'h0F0);
    seek_a(560, 0); check("a_bar_560", {a_red, a_green, a_blue}, 12'hFFF);
    seek_a(639, 0); check("a_bar_639", {a_red, a_green, a_blue, a_display_on}, {12'hFFF, 1'b1});
    seek_a(640, 0); check("a_blank_640", {a_red, a_green, a_blue, a_display_on}, 13'h0);
    seek_a(655, 0); check("a_hs_655", a_h_sync, 1);
    seek_a(656, 0); check("a_hs_656", a_h_sync, 0);
    seek_a(751, 0); check("a_hs_751", a_h_sync, 0);
    seek_a(752, 0); check("a_hs_752", a_h_sync, 1);
    seek_a(0, 1);   check("a_bar_0_1", {a_red, a_green, a_blue}, 12'h000);
    a_mode = 2'd2;
    seek_a(80, 1);  check("a_midframe_bar", {a_red, a_green, a_blue}, 12'h00F);
    seek_a(0, 4);   check("a_vfp", {a_display_on, a_v_sync}, 2'b01);
    seek_a(0, 5);   check("a_vs_5", a_v_sync, 0);
    seek_a(799, 5); check("a_vs_799_5", a_v_sync, 0);
    seek_a(0, 6);   check("a_vs_6", a_v_sync, 1);

    // Frame 1: checkerboard; switch to gradient partway through.
    seek_a(0, 0);
    fa1 = cyc;
    check("a_fs1", a_frame_start, 1);
    check("a_frame_period1", 32'(fa1 - fa0), 22400);
    check("a_chk_0_0", {a_red, a_green, a_blue}, 12'h000);
    seek_a(32, 1);  check("a_chk_32_1", {a_red, a_green, a_blue}, 12'hFFF);
    seek_a(64, 1);  check("a_chk_64_1", {a_red, a_green, a_blue}, 12'h000);
    seek_a(0, 2);
    a_mode = 2'd3;
    seek_a(32, 3);  check("a_chk_32_3", {a_red, a_green, a_blue}, 12'hFFF);

    // Frame 2: gradient.
    seek_a(0, 0);
    fa2 = cyc;
    check("a_fs2", a_frame_start, 1);
    check("a_frame_period2", 32'(fa2 - fa1), 22400);
    seek_a(320, 1); check("a_grad_320_1", {a_red, a_green, a_blue}, 12'h540);
    seek_a(639, 3); check("a_grad_639_3", {a_red, a_green, a_blue}, 12'h9C0);

    // Mid-frame reset aborts the frame.
    a_rst = 1'b1;
    @(posedge clk);
    #1;
    check("a_mrst_xy", {a_pix_x, a_pix_y}, 20'h0);
    check("a_mrst_rgb", {a_red, a_green, a_blue}, 12'h000);
    check("a_mrst_syncs", {a_h_sync, a_v_sync}, 2'b11);
    check("a_mrst_flags", {a_display_on, a_pix_tick, a_frame_start}, 3'b000);
    a_rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      #1;
      check("a_post_rst_tick", a_pix_tick, 32'(i == 4));
    end
    check("a_post_rst_xy", {a_pix_x, a_pix_y}, 20'h0);
    check("a_post_rst_fs", a_frame_start, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
